mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the one-bit 4:1 mux datapath. It shares the mux between four requesters. It grants one requester at a time, drives the 2-bit mux select, and presents a registered copy of the selected data bit. It sits directly in front of `one_bit_4to1mux` and replaces static select wiring in the Lab 2 datapath.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles when another requester is waiting. Used only with the timeout feature. Legal range 1..15.
- `HOLD_W`, default 4: width of the hold counter. Must satisfy `2**HOLD_W > MAX_HOLD`.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  4: request per requester; bit 0 maps to mux input u, bit 1 to v, bit 2 to w, bit 3 to x.
- `data_in`  in  4: data bit per requester, same bit mapping as `req`.
- `gnt`  out  4: one-hot grant, registered.
- `sel`  out  2: mux select, registered; equals the index of the granted requester.
- `valid`  out  1: high while a grant is held.
- `m`  out  1: registered `data_in[sel]`.

## Operation
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If `req` is nonzero, pick the first set bit searching upward, modulo 4, from `last+1`. Load `gnt`, `sel` and `last`, then go to GRANT.
  - If `req` is zero, stay in IDLE.
- GRANT:
  - Hold while `req[sel]` stays high.
  - When `req[sel]` drops, clear `gnt` and `valid` and return to IDLE. The cycle in IDLE is always a one-cycle bubble before the next grant.
- Other requests during GRANT are ignored until release. Requests are level, not latched, so a request that drops before it is serviced is lost.
- `m` updates every cycle to `data_in[sel]` while `valid` is high. It holds its last value when `valid` is low.
- Reset values: `gnt`=0000, `sel`=00, `valid`=0, `m`=0, state=IDLE, `last`=3, hold counter=0. With `last`=3, requester 0 has first priority after reset.
- Reset asserted mid-grant returns to the reset values immediately, asynchronously. No release is signalled.

## Timing
- Grant latency:
  - `req` is sampled at edge k while in IDLE.
  - `gnt`, `sel` and `valid` become valid after edge k.
  - `m` reflects `data_in[sel]` after edge k+1.
- Release:
  - `req[sel]` is sampled low at edge k in GRANT.
  - `valid` falls after edge k.
  - The earliest next grant is after edge k+1.
- Back-to-back occupancy: one requester holding continuously never releases unless the timeout is compiled in. Each grant therefore costs a minimum of 2 cycles: grant plus bubble.
- Simultaneous requests in IDLE are resolved purely by rotation from `last`. There are no fixed priorities.

## Configuration
- Macro `MUX4_ARB_TIMEOUT_EN` controls a forced-release timeout.
- Defined:
  - The hold counter counts GRANT cycles and is cleared on entry to GRANT.
  - When the count reaches `MAX_HOLD` and any other `req` bit is high, the grant is force-released. The FSM then goes to IDLE exactly as on a voluntary release.
  - The counter saturates at `MAX_HOLD` if no other requester is waiting.
- Undefined:
  - No counter is built. Grants are held indefinitely until `req[sel]` drops.

## Structure
- Shared package `mux4_arb_pkg` holds:
  - the state enum, `ST_IDLE`=0 and `ST_GRANT`=1;
  - `NUM_REQ`=4;
  - the select/one-hot conversion function.
- Sub-module `rr_pick4` is purely combinational. It takes `req[3:0]` and `last[1:0]` and returns `idx[1:0]` and `any`.
- The top level holds the FSM, registers and optional counter.

## Test plan
1. Reset then `req`=0001, `data_in`=0001.
   - After 1 edge: `gnt`=0001, `sel`=00, `valid`=1.
   - After 2 edges: `m`=1.
2. `req`=1111 held with each requester dropping its bit one cycle after being granted.
   - Grant order is 0, 1, 2, 3, 0.
   - There is one IDLE bubble between grants.
3. Requester 2 holds `req` for 5 cycles while `data_in[2]` toggles 1, 0, 1, 1, 0.
   - `m` follows one cycle late.
   - `sel`=10 throughout.
4. With `MUX4_ARB_TIMEOUT_EN` and `MAX_HOLD`=3: `req`=0011 held constantly.
   - Requester 0 is granted for 3 cycles, then bubble, then requester 1 for 3 cycles, then requester 0.
   - Without the macro, requester 0 holds forever.
5. `rst_n` is pulsed low mid-grant at a non-edge time.
   - `gnt`=0000, `valid`=0 and `m`=0 take effect immediately.
   - The next grant goes to the lowest set `req` bit.
6. `req`=0100 is raised for one cycle while requester 1 holds.
   - Requester 2 is never granted.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [1:0] s);
    sel_to_onehot = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set req bit searching upward, mod 4,
// starting at last+1.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         idx,
  output logic               any
);

  // Scan from farthest to nearest so the nearest set bit overwrites the rest.
  always_comb begin
    idx = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[last + 2'(i)]) idx = last + 2'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of the one-bit 4:1 mux.
// Optional forced-release timeout enabled by defining MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               valid,
  output logic               m
);

  if (MAX_HOLD < 1 || MAX_HOLD > 15 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
    $error("mux4_rr_arbiter: illegal MAX_HOLD/HOLD_W combination");
  end

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_last;
  logic [1:0]         r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_valid;
  logic               r_m;
  logic [1:0]         w_pick_idx;
  logic               w_pick_any;
  logic               w_load;
  logic               w_release;
  logic               w_timeout;

  rr_pick4 u_pick (
    .req  (req),
    .last (r_last),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold;
  logic              w_others;

  // r_hold is 0 in the first grant cycle, so MAX_HOLD-1 marks the last allowed one.
  assign w_others  = |(req & ~r_gnt);
  assign w_timeout = (r_state == ST_GRANT) && w_others &&
                     (r_hold >= HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_load) begin
      r_hold <= '0;
    end else if (r_state == ST_GRANT && r_hold != HOLD_W'(MAX_HOLD)) begin
      r_hold <= r_hold + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_any) w_next = ST_GRANT;
      ST_GRANT: if (!req[r_sel] || w_timeout) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load    = (r_state == ST_IDLE) && w_pick_any;
    w_release = (r_state == ST_GRANT) && (!req[r_sel] || w_timeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_last  <= 2'd3;
      r_m     <= 1'b0;
    end else begin
      if (w_load) begin
        r_gnt   <= sel_to_onehot(w_pick_idx);
        r_sel   <= w_pick_idx;
        r_last  <= w_pick_idx;
        r_valid <= 1'b1;
      end else if (w_release) begin
        r_gnt   <= '0;
        r_valid <= 1'b0;
      end
      if (r_valid) r_m <= data_in[r_sel];
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign m     = r_m;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (default or timeout build).
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       m;

  int n_checks = 0;
  int n_errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(3), .HOLD_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .m       (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req     = 4'b0000;
    data_in = 4'b0000;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    logic [3:0] oh;
    logic [1:0] s;
    oh = 4'b0001 << idx;
    s  = 2'(idx);
    check({tag, "_gnt"}, 8'(gnt), 8'(oh));
    check({tag, "_sel"}, 8'(sel), 8'(s));
    check({tag, "_valid"}, 8'(valid), 8'h01);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_gnt"}, 8'(gnt), 8'h00);
    check({tag, "_valid"}, 8'(valid), 8'h00);
  endtask

  int         order[5] = '{0, 1, 2, 3, 0};
  logic [4:0] t3_data  = 5'b01101;  // bit i is the data for cycle i: 1,0,1,1,0

  initial begin
    // Test 1: reset values, single request, latency
    do_reset();
    expect_idle("rst");
    check("rst_sel", 8'(sel), 8'h00);
    check("rst_m", 8'(m), 8'h00);
    req = 4'b0001; data_in = 4'b0001;
    step();
    expect_grant("t1", 0);
    check("t1_m_early", 8'(m), 8'h00);
    step();
    check("t1_m", 8'(m), 8'h01);
    req = 4'b0000;
    step();
    expect_idle("t1_rel");

    // Test 2: rotation under full request with one-cycle bubbles
    do_reset();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      expect_grant("t2", order[i]);
      req = 4'b1111 & ~(4'b0001 << order[i]);
      step();
      expect_idle("t2_bubble");
      req = 4'b1111;
      step();
    end
    req = 4'b0000;
    step();
    step();
    expect_idle("t2_end");

    // Test 3: m follows data_in[2] one cycle late
    req = 4'b0100; data_in = 4'b0000;
    step();
    expect_grant("t3", 2);
    for (int i = 0; i < 5; i++) begin
      data_in = {1'b0, t3_data[i], 2'b00};
      step();
      check("t3_m", 8'(m), 8'(t3_data[i]));
      check("t3_sel", 8'(sel), 8'h02);
    end
    req = 4'b0000;
    step();
    expect_idle("t3_rel");
    check("t3_m_rel", 8'(m), 8'h00);
    data_in = 4'b1111;
    step();
    check("t3_m_hold", 8'(m), 8'h00);

    // Test 4: two constant requesters
    do_reset();
    req = 4'b0011;
    step();
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        expect_grant("t4_hold", r);
        step();
      end
      expect_idle("t4_bubble");
      step();
    end
    expect_grant("t4_back", 0);
`else
    for (int c = 0; c < 8; c++) begin
      expect_grant("t4_hold", 0);
      step();
    end
`endif

    // Test 5: asynchronous reset mid-grant
    req = 4'b0000;
    step();
    req = 4'b0100; data_in = 4'b0100;
    step();
    step();
    expect_grant("t5_pre", 2);
    check("t5_m_pre", 8'(m), 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    expect_idle("t5_async");
    check("t5_m_async", 8'(m), 8'h00);
    check("t5_sel_async", 8'(sel), 8'h00);
    #1;
    rst_n = 1'b1;
    req = 4'b1110;
    step();
    expect_grant("t5_next", 1);

    // Test 6: brief request from 2 while 1 holds is lost
    req = 4'b0010;
    step();
    expect_grant("t6_a", 1);
    req = 4'b0110;
    step();
    expect_grant("t6_b", 1);
    req = 4'b0010;
    step();
    expect_grant("t6_c", 1);
    req = 4'b0000;
    step();
    expect_idle("t6_rel");
    step();
    expect_idle("t6_idle");
    step();
    expect_idle("t6_idle2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
